// File: rtl/g3_pkg.sv
// Shared types and default sizing for the G3 rule-table controller.
// Imported by g3_rr_arb2 and g3_table_ctrl.
package g3_pkg;

    localparam int unsigned G3_INDEX_BIT_LEN    = 11;
    localparam int unsigned G3_PACKET_BIT_LEN   = 104;
    localparam int unsigned G3_ENTRY_DATA_WIDTH = 98;
    localparam int unsigned G3_MAX_HOPS         = 16;
    localparam int unsigned G3_NULL_INDEX       = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_RESULT = 3'd3,
        ST_WRITE  = 3'd4
    } g3_state_e;

endpackage

// File: rtl/g3_rr_arb2.sv
// Two-requester round-robin arbiter (search vs. update) for the shared table port.
// A single last-grant flag picks the other requester on a collision; reset favours update.
module g3_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_s,
    input  logic req_u,
    output logic rdy_s,
    output logic rdy_u
);

    logic last_upd;
    logic both;

    assign both  = req_s & req_u;
    assign rdy_s = en & ~(both & ~last_upd);
    assign rdy_u = en & ~(both & last_upd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_upd <= 1'b0;
        end else if (req_s && rdy_s) begin
            last_upd <= 1'b0;
        end else if (req_u && rdy_u) begin
            last_upd <= 1'b1;
        end
    end

endmodule

// File: rtl/g3_table_ctrl.sv
// Lookup chain walker and table-port sequencer for one G3 rule table.
// Defining G3_CTRL_STATS_EN adds saturating lookup/hit/write counters with a sync clear.
//
// state  | meaning
// IDLE   | accepting search or update requests (round-robin on collision)
// LOOKUP | driving cur_index onto the table, counting one hop
// CHECK  | sampling table match / next_index, deciding hit, miss or next hop
// RESULT | holding the result until res_ready
// WRITE  | single-cycle table write of the latched update
module g3_table_ctrl
    import g3_pkg::*;
#(
    parameter int unsigned INDEX_BIT_LEN    = G3_INDEX_BIT_LEN,
    parameter int unsigned PACKET_BIT_LEN   = G3_PACKET_BIT_LEN,
    parameter int unsigned ENTRY_DATA_WIDTH = G3_ENTRY_DATA_WIDTH,
    parameter int unsigned MAX_HOPS         = G3_MAX_HOPS,
    parameter int unsigned NULL_INDEX       = G3_NULL_INDEX,
    localparam int unsigned HW              = $clog2(MAX_HOPS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        search_valid,
    output logic                        search_ready,
    input  logic [INDEX_BIT_LEN-1:0]    search_head,
    input  logic [PACKET_BIT_LEN-1:0]   search_tuple,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        res_match,
    output logic [INDEX_BIT_LEN-1:0]    res_ruleID,
    output logic [HW-1:0]               res_hops,
    input  logic                        upd_valid,
    output logic                        upd_ready,
    input  logic [INDEX_BIT_LEN-1:0]    upd_index,
    input  logic [ENTRY_DATA_WIDTH-1:0] upd_data,
    output logic                        tbl_we,
    output logic [ENTRY_DATA_WIDTH-1:0] tbl_din,
    output logic [INDEX_BIT_LEN-1:0]    tbl_search_index,
    output logic [PACKET_BIT_LEN-1:0]   tbl_tupleData,
    input  logic                        tbl_match,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_ruleID,
    input  logic [INDEX_BIT_LEN-1:0]    tbl_next_index
`ifdef G3_CTRL_STATS_EN
    ,
    input  logic                        stat_clear,
    output logic [31:0]                 stat_lookups,
    output logic [31:0]                 stat_hits,
    output logic [31:0]                 stat_writes
`endif
);

    localparam logic [INDEX_BIT_LEN-1:0] NULL_W     = INDEX_BIT_LEN'(NULL_INDEX);
    localparam logic [HW-1:0]            MAX_HOPS_W = HW'(MAX_HOPS);

    g3_state_e                   state, state_nxt;
    logic                        run;
    logic                        idle_en;
    logic                        acc_s, acc_u;
    logic                        chain_end;
    logic [INDEX_BIT_LEN-1:0]    cur_index;
    logic [INDEX_BIT_LEN-1:0]    wr_index;
    logic [INDEX_BIT_LEN-1:0]    rule_q;
    logic [ENTRY_DATA_WIDTH-1:0] wr_data;
    logic [PACKET_BIT_LEN-1:0]   tuple_q;
    logic [HW-1:0]               hops;
    logic                        match_q;

    // run keeps both readies low until the first edge after reset release
    assign idle_en = run && (state == ST_IDLE);

    g3_rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idle_en),
        .req_s (search_valid),
        .req_u (upd_valid),
        .rdy_s (search_ready),
        .rdy_u (upd_ready)
    );

    assign acc_s         = search_valid & search_ready;
    assign acc_u         = upd_valid & upd_ready;
    assign chain_end     = tbl_match || (tbl_next_index == NULL_W) || (hops == MAX_HOPS_W);
    assign tbl_tupleData = tuple_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt        = state;
        res_valid        = 1'b0;
        res_match        = 1'b0;
        res_ruleID       = '0;
        res_hops         = '0;
        tbl_we           = 1'b0;
        tbl_din          = '0;
        tbl_search_index = '0;
        case (state)
            ST_IDLE: begin
                if (acc_s) begin
                    state_nxt = (search_head == NULL_W) ? ST_RESULT : ST_LOOKUP;
                end else if (acc_u) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_LOOKUP: begin
                tbl_search_index = cur_index;
                state_nxt        = ST_CHECK;
            end
            ST_CHECK: begin
                state_nxt = chain_end ? ST_RESULT : ST_LOOKUP;
            end
            ST_RESULT: begin
                res_valid  = 1'b1;
                res_match  = match_q;
                res_ruleID = rule_q;
                res_hops   = hops;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                tbl_we           = 1'b1;
                tbl_din          = wr_data;
                tbl_search_index = wr_index;
                state_nxt        = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_index <= '0;
            wr_index  <= '0;
            wr_data   <= '0;
            tuple_q   <= '0;
            hops      <= '0;
            match_q   <= 1'b0;
            rule_q    <= '0;
        end else begin
            if (acc_s) begin
                cur_index <= search_head;
                tuple_q   <= search_tuple;
                hops      <= '0;
                match_q   <= 1'b0;
                rule_q    <= '0;
            end
            if (acc_u) begin
                wr_index <= upd_index;
                wr_data  <= upd_data;
            end
            if (state == ST_LOOKUP && hops != MAX_HOPS_W) begin
                hops <= hops + 1'b1;
            end
            if (state == ST_CHECK) begin
                if (tbl_match) begin
                    match_q <= 1'b1;
                    rule_q  <= tbl_ruleID;
                end else if (!chain_end) begin
                    cur_index <= tbl_next_index;
                end
            end
        end
    end

`ifdef G3_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_writes  <= '0;
        end else if (stat_clear) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_writes  <= '0;
        end else begin
            if (acc_s && stat_lookups != '1) begin
                stat_lookups <= stat_lookups + 32'd1;
            end
            if (state == ST_CHECK && tbl_match && stat_hits != '1) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (state == ST_WRITE && stat_writes != '1) begin
                stat_writes <= stat_writes + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_g3_table_ctrl.sv
// Self-checking bench for g3_table_ctrl: directed vector table, arbitration and reset
// sequences, and randomized chains checked against a chain-walking reference model.
module tb_g3_table_ctrl;
    import g3_pkg::*;

    localparam int IW = 11;
    localparam int PW = 104;
    localparam int DW = 98;
    localparam int MH = 16;
    localparam int HW = $clog2(MH + 1);

    logic          clk;
    logic          rst_n;
    logic          search_valid, search_ready;
    logic [IW-1:0] search_head;
    logic [PW-1:0] search_tuple;
    logic          res_valid, res_ready, res_match;
    logic [IW-1:0] res_ruleID;
    logic [HW-1:0] res_hops;
    logic          upd_valid, upd_ready;
    logic [IW-1:0] upd_index;
    logic [DW-1:0] upd_data;
    logic          tbl_we;
    logic [DW-1:0] tbl_din;
    logic [IW-1:0] tbl_search_index;
    logic [PW-1:0] tbl_tupleData;
    logic          tbl_match;
    logic [IW-1:0] tbl_ruleID, tbl_next_index;
`ifdef G3_CTRL_STATS_EN
    logic          stat_clear;
    logic [31:0]   stat_lookups, stat_hits, stat_writes;
`endif

    int n_checks;
    int n_errors;
    int we_count;

    g3_table_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .search_valid     (search_valid),
        .search_ready     (search_ready),
        .search_head      (search_head),
        .search_tuple     (search_tuple),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_match        (res_match),
        .res_ruleID       (res_ruleID),
        .res_hops         (res_hops),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .upd_index        (upd_index),
        .upd_data         (upd_data),
        .tbl_we           (tbl_we),
        .tbl_din          (tbl_din),
        .tbl_search_index (tbl_search_index),
        .tbl_tupleData    (tbl_tupleData),
        .tbl_match        (tbl_match),
        .tbl_ruleID       (tbl_ruleID),
        .tbl_next_index   (tbl_next_index)
`ifdef G3_CTRL_STATS_EN
        ,
        .stat_clear       (stat_clear),
        .stat_lookups     (stat_lookups),
        .stat_hits        (stat_hits),
        .stat_writes      (stat_writes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // table model: outputs registered one cycle after the index
    bit          tm[2048];
    bit [IW-1:0] trule[2048];
    bit [IW-1:0] tnext[2048];

    always @(posedge clk) begin
        tbl_match      <= tm[tbl_search_index];
        tbl_ruleID     <= trule[tbl_search_index];
        tbl_next_index <= tnext[tbl_search_index];
    end

    always @(negedge clk) begin
        if (tbl_we === 1'b1) we_count++;
    end

    typedef struct {
        bit [IW-1:0] head;
        bit          exp_m;
        int          exp_rid;
        int          exp_hops;
        int          exp_lat;
    } vec_t;

    typedef struct {
        int          vec;
        bit [IW-1:0] idx;
        bit          m;
        bit [IW-1:0] rule;
        bit [IW-1:0] nxt;
    } ent_t;

    vec_t vecs[6];
    ent_t ents[$];

    function automatic vec_t mk_vec(int head, bit m, int rid, int hops, int lat);
        vec_t v;
        v.head     = head[IW-1:0];
        v.exp_m    = m;
        v.exp_rid  = rid;
        v.exp_hops = hops;
        v.exp_lat  = lat;
        return v;
    endfunction

    function automatic ent_t mk_ent(int vec, int idx, bit m, int rule, int nxt);
        ent_t e;
        e.vec  = vec;
        e.idx  = idx[IW-1:0];
        e.m    = m;
        e.rule = rule[IW-1:0];
        e.nxt  = nxt[IW-1:0];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 2048; i++) begin
            tm[i]    = 1'b0;
            trule[i] = '0;
            tnext[i] = '0;
        end
    endtask

    task automatic program_vec(input int v);
        clear_table();
        foreach (ents[k]) begin
            if (ents[k].vec == v) begin
                tm[ents[k].idx]    = ents[k].m;
                trule[ents[k].idx] = ents[k].rule;
                tnext[ents[k].idx] = ents[k].nxt;
            end
        end
    endtask

    // reference: walk the chain with plain loop arithmetic
    function automatic void ref_lookup(input bit [IW-1:0] head, output bit m, output int rid,
                                       output int hops, output int lat);
        bit [IW-1:0] idx;
        idx  = head;
        m    = 1'b0;
        rid  = 0;
        hops = 0;
        if (head != 0) begin
            for (int k = 0; k < MH; k++) begin
                hops++;
                if (tm[idx]) begin
                    m   = 1'b1;
                    rid = int'(trule[idx]);
                    break;
                end
                if (tnext[idx] == 0) break;
                idx = tnext[idx];
            end
        end
        lat = (head == 0) ? 1 : 2 * hops + 1;
    endfunction

    function automatic logic [PW-1:0] rand_tuple();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    task automatic do_lookup(input string nm, input bit [IW-1:0] head, input bit em,
                             input int erid, input int ehops, input int elat, input int hold);
        int            lat;
        bit            got;
        logic [PW-1:0] tup;
        tup = rand_tuple();
        @(negedge clk);
        search_valid = 1'b1;
        search_head  = head;
        search_tuple = tup;
        #1;
        chk({nm, "_ready"}, 128'(search_ready), 128'(1));
        @(posedge clk);
        #1 search_valid = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        chk({nm, "_resvalid"}, 128'(got), 128'(1));
        if (got) begin
            chk({nm, "_latency"}, 128'(lat), 128'(elat));
            chk({nm, "_match"}, 128'(res_match), 128'(em));
            chk({nm, "_ruleID"}, 128'(res_ruleID), 128'(erid));
            chk({nm, "_hops"}, 128'(res_hops), 128'(ehops));
            chk({nm, "_tuple"}, 128'(tbl_tupleData), 128'(tup));
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                chk({nm, "_hold_valid"}, 128'(res_valid), 128'(1));
                chk({nm, "_hold_ruleID"}, 128'(res_ruleID), 128'(erid));
                chk({nm, "_hold_noready"}, 128'({search_ready, upd_ready}), 128'(0));
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1 res_ready = 1'b0;
            @(negedge clk);
            chk({nm, "_idle"}, 128'({res_valid, search_ready}), 128'(1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        bit          m;
        int          rid, hops, lat;
        logic [IW-1:0] ui;
        logic [127:0]  ud;

        n_checks = 0;
        n_errors = 0;
        we_count = 0;
        rst_n = 1'b0;
        search_valid = 1'b0;
        search_head = '0;
        search_tuple = '0;
        res_ready = 1'b0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_data = '0;
        tbl_match = 1'b0;
        tbl_ruleID = '0;
        tbl_next_index = '0;
`ifdef G3_CTRL_STATS_EN
        stat_clear = 1'b0;
`endif
        clear_table();

        vecs[0] = mk_vec(5, 1'b1, 'h2A, 1, 3);
        vecs[1] = mk_vec(5, 1'b1, 7, 3, 7);
        vecs[2] = mk_vec(5, 1'b0, 0, 1, 3);
        vecs[3] = mk_vec(0, 1'b0, 0, 0, 1);
        vecs[4] = mk_vec(3, 1'b0, 0, 16, 33);
        vecs[5] = mk_vec(100, 1'b1, 'h7FF, 2, 5);
        ents.push_back(mk_ent(0, 5, 1'b1, 'h2A, 0));
        ents.push_back(mk_ent(1, 5, 1'b0, 0, 9));
        ents.push_back(mk_ent(1, 9, 1'b0, 0, 12));
        ents.push_back(mk_ent(1, 12, 1'b1, 7, 0));
        ents.push_back(mk_ent(2, 5, 1'b0, 33, 0));
        ents.push_back(mk_ent(4, 3, 1'b0, 0, 4));
        ents.push_back(mk_ent(4, 4, 1'b0, 0, 3));
        ents.push_back(mk_ent(5, 100, 1'b0, 0, 200));
        ents.push_back(mk_ent(5, 200, 1'b1, 'h7FF, 300));

        // reset state and ready release timing
        repeat (3) @(negedge clk);
        chk("rst_readies", 128'({search_ready, upd_ready}), 128'(0));
        chk("rst_res", 128'({res_valid, res_match, res_ruleID, res_hops}), 128'(0));
        chk("rst_tbl", 128'({tbl_we, tbl_din, tbl_search_index}), 128'(0));
        chk("rst_tuple", 128'(tbl_tupleData), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_edge", 128'({search_ready, upd_ready}), 128'(0));
        @(negedge clk);
        chk("rel_ready_after_edge", 128'({search_ready, upd_ready}), 128'(3));

        // simultaneous requests: grants alternate U,S,U,S from reset
        for (int i = 0; i < 4; i++) begin
            bit exp_u;
            exp_u = (i % 2 == 0);
            ui = IW'($urandom_range(1, 2047));
            ud = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            search_valid = 1'b1;
            search_head  = '0;
            search_tuple = rand_tuple();
            upd_valid    = 1'b1;
            upd_index    = ui;
            upd_data     = ud[DW-1:0];
            #1;
            chk($sformatf("arb%0d_upd_ready", i), 128'(upd_ready), 128'(exp_u));
            chk($sformatf("arb%0d_search_ready", i), 128'(search_ready), 128'(!exp_u));
            @(posedge clk);
            #1;
            search_valid = 1'b0;
            upd_valid    = 1'b0;
            @(negedge clk);
            if (exp_u) begin
                chk($sformatf("arb%0d_we", i), 128'({tbl_we, res_valid}), 128'(2));
                chk($sformatf("arb%0d_widx", i), 128'(tbl_search_index), 128'(ui));
                chk($sformatf("arb%0d_wdata", i), 128'(tbl_din), 128'(ud[DW-1:0]));
                @(negedge clk);
                chk($sformatf("arb%0d_we_done", i), 128'({tbl_we, search_ready, upd_ready}), 128'(3));
            end else begin
                chk($sformatf("arb%0d_null_res", i), 128'({res_valid, res_match, res_hops}), 128'({1'b1, 1'b0, 5'd0}));
                res_ready = 1'b1;
                @(posedge clk);
                #1 res_ready = 1'b0;
            end
        end

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            program_vec(i);
            do_lookup($sformatf("vec%0d", i), vecs[i].head, vecs[i].exp_m, vecs[i].exp_rid,
                      vecs[i].exp_hops, vecs[i].exp_lat, i % 3);
        end

        // reset pulse during CHECK drops the lookup
        program_vec(1);
        @(negedge clk);
        search_valid = 1'b1;
        search_head  = 11'd5;
        search_tuple = rand_tuple();
        @(posedge clk);
        #1 search_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstchk_res", 128'({res_valid, res_match, res_ruleID, res_hops}), 128'(0));
        chk("rstchk_tbl", 128'({tbl_we, tbl_din, tbl_search_index, search_ready, upd_ready}), 128'(0));
        chk("rstchk_tuple", 128'(tbl_tupleData), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) cnt++;
        end
        chk("rstchk_no_result", 128'(cnt), 128'(0));
        chk("rstchk_idle_ready", 128'({search_ready, upd_ready}), 128'(3));
        do_lookup("rstchk_resume", 11'd5, 1'b1, 7, 3, 7, 1);

        // reset during WRITE clears the write strobe at once
        @(negedge clk);
        upd_valid = 1'b1;
        upd_index = 11'd77;
        upd_data  = DW'(98'h3_1234_5678);
        @(posedge clk);
        #1 upd_valid = 1'b0;
        @(negedge clk);
        chk("rstwr_we_before", 128'({tbl_we, tbl_search_index}), 128'({1'b1, 11'd77}));
        #2 rst_n = 1'b0;
        #1;
        chk("rstwr_we_after", 128'({tbl_we, tbl_din, tbl_search_index}), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_idle", 128'({tbl_we, search_ready, upd_ready}), 128'(3));

        // randomized chains against the reference model
        for (int r = 0; r < 40; r++) begin
            bit [IW-1:0] head;
            clear_table();
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx        = $urandom_range(1, 31);
                tm[idx]    = ($urandom_range(0, 5) == 0);
                trule[idx] = IW'($urandom_range(0, 2047));
                tnext[idx] = IW'($urandom_range(0, 31));
            end
            head = ($urandom_range(0, 9) == 0) ? '0 : IW'($urandom_range(1, 31));
            ref_lookup(head, m, rid, hops, lat);
            do_lookup($sformatf("rnd%0d", r), head, m, rid, hops, lat, int'($urandom_range(0, 2)));
        end

        chk("we_cycle_count", 128'(we_count), 128'(3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
